// File: rtl/ahb_lite_master_if.sv
// Command/response and AHB-Lite bus bundle for ahb_lite_master.
// The master modport is the initiator's view; the slave modport is the view of
// whatever sits on the other side (host logic plus the AHB slave).
interface ahb_lite_master_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  // Command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  // Response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // AHB-Lite bus
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [1:0]        hsize;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output hsel, haddr, htrans, hsize, hwrite, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  hsel, haddr, htrans, hsize, hwrite, hwdata
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding, non-pipelined AHB-Lite initiator.
// One accepted command becomes one NONSEQ single transfer; the result comes
// back as a one-cycle rsp_valid pulse. All outputs are registered.
// Optional watchdog: define AHB_MASTER_TIMEOUT_EN to abort transfers that
// stall for TIMEOUT_CYCLES hready-low cycles.
module ahb_lite_master #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               nRst,
  ahb_lite_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              hsel_q, hsel_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [1:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic accept_c;
  logic expire_c;

  assign accept_c = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Count hready-low cycles of the current transfer; cleared on acceptance.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (accept_c) begin
      wait_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && !bus.hready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Expiry fires on the edge where the count would reach TIMEOUT_CYCLES.
  // It needs hready low, so it can never coincide with a normal completion.
  assign expire_c = (state_q != ST_IDLE) && !bus.hready &&
                    (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign expire_c           = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    hsel_d        = hsel_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hsize_d       = hsize_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    wdata_d       = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d     = ST_ADDR;
          cmd_ready_d = 1'b0;
          hsel_d      = 1'b1;
          htrans_d    = HTRANS_NONSEQ;
          haddr_d     = bus.cmd_addr;
          hsize_d     = bus.cmd_size;
          hwrite_d    = bus.cmd_write;
          wdata_d     = bus.cmd_wdata;
        end
      end

      ST_ADDR: begin
        // Address phase held stable until the slave takes it.
        if (bus.hready) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      ST_DATA: begin
        if (bus.hready) begin
          state_d       = ST_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.hresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (bus.hresp || hwrite_q) ? '0 : bus.hrdata;
        end else if (bus.hresp) begin
          state_d = ST_ERR;
        end
      end

      ST_ERR: begin
        // Second cycle of the two-cycle ERROR response ends the transfer.
        if (bus.hready) begin
          state_d       = ST_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (expire_c) begin
      state_d       = ST_IDLE;
      cmd_ready_d   = 1'b1;
      hsel_d        = 1'b0;
      htrans_d      = HTRANS_IDLE;
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      hsel_q        <= 1'b0;
      haddr_q       <= '0;
      htrans_q      <= HTRANS_IDLE;
      hsize_q       <= 2'b00;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      hsel_q        <= hsel_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hsize_q       <= hsize_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      wdata_q       <= wdata_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.hsel        = hsel_q;
  assign bus.haddr       = haddr_q;
  assign bus.htrans      = htrans_q;
  assign bus.hsize       = hsize_q;
  assign bus.hwrite      = hwrite_q;
  assign bus.hwdata      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: the bench plays host and AHB slave,
// and predicts bus activity, latency and response from the transfer rules.
module tb_ahb_lite_master;

  localparam int unsigned ADDR_W         = 7;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          MAX_CYC        = 40;

  logic clk = 1'b0;
  logic nRst;
  int   n_chk  = 0;
  int   n_pass = 0;

  ahb_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_lite_master #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ready_before;
    logic              a_hsel;
    logic [1:0]        a_htrans;
    logic [ADDR_W-1:0] a_haddr;
    logic [1:0]        a_hsize;
    logic              a_hwrite;
    logic              a_ready;
    logic              a_rsp_valid;
    logic [DATA_W-1:0] d_hwdata;
    int                bad_busy;
    int                nonseq;
    int                latency;
    logic              r_err;
    logic              r_to;
    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
  } obs_t;

  // Issue one command and act as the slave: aw address-phase waits, waits
  // data-phase waits, then OKAY (with srd) or a two-cycle ERROR.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                          input logic [DATA_W-1:0] wd, input int aw, input int waits,
                          input bit err, input logic [DATA_W-1:0] srd, output obs_t o);
    int cyc;
    int k;
    bit done;
    o.bad_busy = 0; o.nonseq = 0; o.latency = -1; o.d_hwdata = '0;
    o.r_err = 1'b0; o.r_to = 1'b0; o.r_ready = 1'b0; o.r_rdata = '0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a;
    bus.cmd_size = sz; bus.cmd_wdata = wd;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = DATA_W'($urandom);
    o.ready_before = bus.cmd_ready;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom); bus.cmd_addr = ADDR_W'($urandom);
    bus.cmd_size = 2'($urandom); bus.cmd_wdata = DATA_W'($urandom);
    o.a_hsel = bus.hsel; o.a_htrans = bus.htrans; o.a_haddr = bus.haddr;
    o.a_hsize = bus.hsize; o.a_hwrite = bus.hwrite; o.a_ready = bus.cmd_ready;
    o.a_rsp_valid = bus.rsp_valid;
    cyc = 1; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      if (bus.htrans === 2'b10) o.nonseq++;
      if (cyc <= aw) begin
        bus.hready = 1'b0; bus.hresp = 1'b0;
      end else if (cyc > aw + 1) begin
        k = cyc - aw - 2;
        if (k < waits) begin
          bus.hready = 1'b0; bus.hresp = 1'b0;
        end else if (err && k == waits) begin
          bus.hready = 1'b0; bus.hresp = 1'b1;
        end else if (err) begin
          bus.hready = 1'b1; bus.hresp = 1'b1;
        end else begin
          bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = srd;
        end
      end
      @(posedge clk); #1;
      cyc++;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = DATA_W'($urandom);
      if (bus.rsp_valid === 1'b1) begin
        done = 1'b1; o.latency = cyc;
        o.r_err = bus.rsp_err; o.r_to = bus.rsp_timeout;
        o.r_rdata = bus.rsp_rdata; o.r_ready = bus.cmd_ready;
      end else if (cyc <= aw + 1) begin
        if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.cmd_ready} !==
            {1'b1, 2'b10, a, sz, w, 1'b0}) o.bad_busy++;
      end else begin
        if (cyc == aw + 2) o.d_hwdata = bus.hwdata;
        if ({bus.hsel, bus.htrans, bus.haddr, bus.cmd_ready} !== {1'b0, 2'b00, a, 1'b0}) o.bad_busy++;
        if (w && bus.hwdata !== wd) o.bad_busy++;
      end
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); else n_pass++;
    n_chk++; if (bus.rsp_timeout !== 1'b0) $display("FAIL rst_rsp_timeout: got %b want 0", bus.rsp_timeout); else n_pass++;
    n_chk++; if (bus.rsp_rdata !== '0) $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); else n_pass++;
    n_chk++; if (bus.hsel !== 1'b0) $display("FAIL rst_hsel: got %b want 0", bus.hsel); else n_pass++;
    n_chk++; if (bus.haddr !== '0) $display("FAIL rst_haddr: got %h want 0", bus.haddr); else n_pass++;
    n_chk++; if (bus.htrans !== 2'b00) $display("FAIL rst_htrans: got %b want 00", bus.htrans); else n_pass++;
    n_chk++; if (bus.hsize !== 2'b00) $display("FAIL rst_hsize: got %b want 00", bus.hsize); else n_pass++;
    n_chk++; if (bus.hwrite !== 1'b0) $display("FAIL rst_hwrite: got %b want 0", bus.hwrite); else n_pass++;
    n_chk++; if (bus.hwdata !== '0) $display("FAIL rst_hwdata: got %h want 0", bus.hwdata); else n_pass++;
    nRst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({bus.cmd_ready, bus.hsel, bus.htrans} !== 4'b1000) $display("FAIL rst_idle_after: got %b want 1000", {bus.cmd_ready, bus.hsel, bus.htrans}); else n_pass++;
  endtask

  task automatic test_write_basic();
    obs_t o;
    run_xfer(1'b1, 7'h00, 2'b10, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, o);
    n_chk++; if (o.ready_before !== 1'b1) $display("FAIL wr_ready: got %b want 1", o.ready_before); else n_pass++;
    n_chk++; if ({o.a_hsel, o.a_htrans} !== 3'b110) $display("FAIL wr_nonseq: got %b want 110", {o.a_hsel, o.a_htrans}); else n_pass++;
    n_chk++; if ({o.a_haddr, o.a_hwrite, o.a_hsize} !== {7'h00, 1'b1, 2'b10}) $display("FAIL wr_addr_phase: got %h/%b/%b want 00/1/10", o.a_haddr, o.a_hwrite, o.a_hsize); else n_pass++;
    n_chk++; if (o.a_ready !== 1'b0) $display("FAIL wr_busy_ready: got %b want 0", o.a_ready); else n_pass++;
    n_chk++; if (o.d_hwdata !== 32'hDEADBEEF) $display("FAIL wr_hwdata: got %h want deadbeef", o.d_hwdata); else n_pass++;
    n_chk++; if (o.latency !== 3) $display("FAIL wr_latency: got %0d want 3", o.latency); else n_pass++;
    n_chk++; if ({o.r_err, o.r_to, o.r_rdata} !== {2'b00, 32'h0}) $display("FAIL wr_rsp: got err %b to %b rdata %h want 0 0 0", o.r_err, o.r_to, o.r_rdata); else n_pass++;
    n_chk++; if (o.bad_busy !== 0) $display("FAIL wr_data_phase: got %0d bad cycles want 0", o.bad_busy); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_read_basic();
    obs_t o;
    run_xfer(1'b0, 7'h41, 2'b00, 32'h1234_5678, 0, 0, 1'b0, 32'h0000_0005, o);
    n_chk++; if ({o.a_haddr, o.a_hwrite, o.a_hsize} !== {7'h41, 1'b0, 2'b00}) $display("FAIL rd_addr_phase: got %h/%b/%b want 41/0/00", o.a_haddr, o.a_hwrite, o.a_hsize); else n_pass++;
    n_chk++; if (o.latency !== 3) $display("FAIL rd_latency: got %0d want 3", o.latency); else n_pass++;
    n_chk++; if (o.r_rdata !== 32'h5) $display("FAIL rd_rdata: got %h want 00000005", o.r_rdata); else n_pass++;
    n_chk++; if (o.r_err !== 1'b0) $display("FAIL rd_err: got %b want 0", o.r_err); else n_pass++;
    n_chk++; if (o.r_ready !== 1'b1) $display("FAIL rd_ready_at_rsp: got %b want 1", o.r_ready); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b0, 32'h5}) $display("FAIL rd_hold: got %b/%h want 0/00000005", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
  endtask

  task automatic test_error();
    obs_t o;
    int   reissue;
    run_xfer(1'b1, 7'h43, 2'b10, 32'hA5A5_0F0F, 0, 0, 1'b1, 32'hFFFF_FFFF, o);
    n_chk++; if (o.latency !== 4) $display("FAIL err_latency: got %0d want 4", o.latency); else n_pass++;
    n_chk++; if ({o.r_err, o.r_rdata} !== {1'b1, 32'h0}) $display("FAIL err_rsp: got err %b rdata %h want 1 0", o.r_err, o.r_rdata); else n_pass++;
    n_chk++; if (o.bad_busy !== 0) $display("FAIL err_idle_bus: got %0d bad cycles want 0", o.bad_busy); else n_pass++;
    n_chk++; if (o.nonseq !== 1) $display("FAIL err_nonseq_count: got %0d want 1", o.nonseq); else n_pass++;
    reissue = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.htrans !== 2'b00 || bus.hsel !== 1'b0 || bus.cmd_ready !== 1'b1) reissue++;
    end
    n_chk++; if (reissue !== 0) $display("FAIL err_no_reissue: got %0d busy cycles want 0", reissue); else n_pass++;
  endtask

  task automatic test_wait_read();
    obs_t o;
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    run_xfer(1'b0, 7'h00, 2'b10, 32'h0, 0, 3, 1'b0, d, o);
    n_chk++; if (o.latency !== 6) $display("FAIL wait_latency: got %0d want 6", o.latency); else n_pass++;
    n_chk++; if (o.bad_busy !== 0) $display("FAIL wait_stable: got %0d bad cycles want 0", o.bad_busy); else n_pass++;
    n_chk++; if (o.r_rdata !== d) $display("FAIL wait_rdata: got %h want %h", o.r_rdata, d); else n_pass++;
    d = DATA_W'($urandom);
    run_xfer(1'b1, 7'h20, 2'b01, d, 2, 1, 1'b0, 32'h0, o);
    n_chk++; if (o.latency !== 6) $display("FAIL awaitlatency: got %0d want 6", o.latency); else n_pass++;
    n_chk++; if (o.bad_busy !== 0 || o.nonseq !== 3) $display("FAIL await_hold: got bad %0d nonseq %0d want 0 3", o.bad_busy, o.nonseq); else n_pass++;
`ifndef AHB_MASTER_TIMEOUT_EN
    run_xfer(1'b0, 7'h44, 2'b10, 32'h0, 0, 20, 1'b0, d, o);
    n_chk++; if (o.latency !== 23) $display("FAIL long_wait_latency: got %0d want 23", o.latency); else n_pass++;
    n_chk++; if ({o.r_err, o.r_to, o.r_rdata} !== {2'b00, d}) $display("FAIL long_wait_rsp: got %b %b %h want 0 0 %h", o.r_err, o.r_to, o.r_rdata, d); else n_pass++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    run_xfer(1'b1, 7'h3F, 2'b10, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0, o1);
    run_xfer(1'b0, 7'h40, 2'b10, 32'h0, 0, 0, 1'b0, 32'h7777_1111, o2);
    n_chk++; if (o2.ready_before !== 1'b1) $display("FAIL b2b_ready_at_rsp: got %b want 1", o2.ready_before); else n_pass++;
    n_chk++; if ({o2.a_hsel, o2.a_htrans, o2.a_haddr, o2.a_hwrite} !== {1'b1, 2'b10, 7'h40, 1'b0}) $display("FAIL b2b_addr_phase: got %b/%b/%h/%b want 1/10/40/0", o2.a_hsel, o2.a_htrans, o2.a_haddr, o2.a_hwrite); else n_pass++;
    n_chk++; if (o2.a_rsp_valid !== 1'b0) $display("FAIL b2b_rsp_pulse: got %b want 0", o2.a_rsp_valid); else n_pass++;
    n_chk++; if (o1.latency !== 3 || o2.latency !== 3) $display("FAIL b2b_latency: got %0d/%0d want 3/3", o1.latency, o2.latency); else n_pass++;
    n_chk++; if (o2.r_rdata !== 32'h7777_1111) $display("FAIL b2b_rdata: got %h want 77771111", o2.r_rdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    obs_t o;
    logic w;
    logic [ADDR_W-1:0] a;
    logic [1:0] sz;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] srd;
    logic [DATA_W-1:0] exp_rd;
    int aw;
    int waits;
    int gap;
    int exp_lat;
    bit err;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom); a = ADDR_W'($urandom); sz = 2'($urandom);
      wd = DATA_W'($urandom); srd = DATA_W'($urandom);
      aw = $urandom_range(0, 1); waits = $urandom_range(0, 3);
      err = ($urandom_range(0, 5) == 0);
      exp_lat = 3 + aw + waits + (err ? 1 : 0);
      exp_rd  = (err || w) ? '0 : srd;
      run_xfer(w, a, sz, wd, aw, waits, err, srd, o);
      n_chk++; if (o.ready_before !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", i, o.ready_before); else n_pass++;
      n_chk++; if ({o.a_hsel, o.a_htrans, o.a_haddr, o.a_hsize, o.a_hwrite, o.a_rsp_valid} !== {1'b1, 2'b10, a, sz, w, 1'b0})
        $display("FAIL rnd%0d_addr_phase: got %b/%b/%h/%b/%b/%b want 1/10/%h/%b/%b/0", i, o.a_hsel, o.a_htrans, o.a_haddr, o.a_hsize, o.a_hwrite, o.a_rsp_valid, a, sz, w); else n_pass++;
      n_chk++; if (o.latency !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, o.latency, exp_lat); else n_pass++;
      n_chk++; if ({o.r_err, o.r_to, o.r_rdata} !== {err, 1'b0, exp_rd}) $display("FAIL rnd%0d_rsp: got %b %b %h want %b 0 %h", i, o.r_err, o.r_to, o.r_rdata, err, exp_rd); else n_pass++;
      n_chk++; if (o.bad_busy !== 0 || o.nonseq !== 1 + aw) $display("FAIL rnd%0d_bus: got bad %0d nonseq %0d want 0 %0d", i, o.bad_busy, o.nonseq, 1 + aw); else n_pass++;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b0, err, exp_rd}) $display("FAIL rnd%0d_hold: got %b %b %h want 0 %b %h", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, err, exp_rd); else n_pass++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 7'h10;
    bus.cmd_size = 2'b10; bus.cmd_wdata = 32'hCAFE_F00D; bus.hready = 1'b1; bus.hresp = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.hready = 1'b0;
    n_chk++; if (bus.hwdata !== 32'hCAFE_F00D) $display("FAIL mid_hwdata: got %h want cafef00d", bus.hwdata); else n_pass++;
    #2 nRst = 1'b0;
    #1;
    n_chk++; if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.hwdata} !== {1'b0, 2'b00, 7'h00, 2'b00, 1'b0, 32'h0})
      $display("FAIL mid_async_bus: got %b/%b/%h/%b/%b/%h want all zero", bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.hwdata); else n_pass++;
    n_chk++; if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL mid_async_rsp: got %b/%b/%b/%h want 1/0/0/0", bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); else n_pass++;
    @(negedge clk);
    nRst = 1'b1; bus.hready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0 || bus.htrans !== 2'b00) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL mid_no_rsp: got activity %b want 0", seen); else n_pass++;
    n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", bus.cmd_ready); else n_pass++;
  endtask

`ifdef AHB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h42;
    bus.cmd_size = 2'b10; bus.hready = 1'b1; bus.hresp = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.hready = 1'b0;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < MAX_CYC) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (cyc !== 1 + int'(TIMEOUT_CYCLES)) $display("FAIL to_latency: got %0d want %0d", cyc, 1 + TIMEOUT_CYCLES); else n_pass++;
    n_chk++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b11) $display("FAIL to_flags: got %b want 11", {bus.rsp_err, bus.rsp_timeout}); else n_pass++;
    n_chk++; if ({bus.hsel, bus.htrans, bus.cmd_ready} !== 4'b0001) $display("FAIL to_idle: got %b want 0001", {bus.hsel, bus.htrans, bus.cmd_ready}); else n_pass++;
    bus.hready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL to_pulse: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_size = 2'b00; bus.cmd_wdata = '0;
    bus.hrdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
    nRst = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_error();
    test_wait_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AHB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
